// File: rtl/seq_divider_if.sv
// seq_divider_if: operand/result bundle between the control unit and the divider
interface seq_divider_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;
  modport master (output start, dividend, divisor, input hi, lo, busy, done, div_zero);
  modport slave  (input start, dividend, divisor, output hi, lo, busy, done, div_zero);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: restoring shift-subtract signed divider with MIPS DIV semantics (hi=remainder, lo=quotient)
module seq_divider #(
  parameter int WIDTH = 32
) (
  input logic          clock,
  input logic          reset,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t           state, next;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] mag;
  logic             sign_a, sign_b;
  logic [WIDTH:0]   shifted, diff;
  logic             accept, zero;
  assign zero    = bus.divisor == '0;
  assign accept  = state == IDLE && bus.start;
  assign shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, mag};
  assign bus.busy = state != IDLE;
  // state register; reset aborts any operation in flight
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next;
  // next state: a zero divisor is answered from IDLE without entering CALC
  always_comb begin
    next = state;
    if (accept && !zero) next = CALC;
    else if (state == CALC && count == CW'(WIDTH - 1)) next = FIX;
    else if (state == FIX) next = IDLE;
  end
  // datapath: operand capture, one restoring iteration per CALC cycle, sign fix-up in FIX
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      count <= '0;
      rem <= '0;
      quo <= '0;
      mag <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      bus.hi <= '0;
      bus.lo <= '0;
      bus.done <= 1'b0;
      bus.div_zero <= 1'b0;
    end else begin
      bus.done <= state == FIX || (accept && zero);
      if (accept) begin
        bus.div_zero <= zero;
        if (!zero) begin
          quo <= bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
          mag <= bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
          rem <= '0;
          sign_a <= bus.dividend[WIDTH-1];
          sign_b <= bus.divisor[WIDTH-1];
          count <= '0;
        end
      end else if (state == CALC) begin
        rem <= diff[WIDTH] ? shifted : diff;
        quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
        count <= count + 1'b1;
      end else if (state == FIX) begin
        bus.lo <= (sign_a ^ sign_b) ? -quo : quo;
        bus.hi <= sign_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
      end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized scoreboard bench for seq_divider against a signed-arithmetic reference
module tb_seq_divider;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          cyc;
    int          lat;
  } exp_t;
  exp_t        q[$];
  exp_t        me;
  logic [31:0] last_lo = '0;
  logic [31:0] last_hi = '0;

  seq_divider_if #(.WIDTH(32)) bus ();
  seq_divider #(.WIDTH(32)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // reference: hardware result equals plain signed division, zero divisor keeps the old result
  task automatic predict(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    e.cyc = cyc;
    if (b == 0) begin
      e.lo = last_lo; e.hi = last_hi; e.dz = 1'b1; e.lat = 1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.lo = 32'h8000_0000; e.hi = 0; e.dz = 1'b0; e.lat = 34;
    end else begin
      e.lo = sa / sb; e.hi = sa % sb; e.dz = 1'b0; e.lat = 34;
    end
    last_lo = e.lo;
    last_hi = e.hi;
    q.push_back(e);
  endtask

  // issue one accepted operation: wait until idle, pulse start, push expectation
  task automatic do_div(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout busy stuck at cycle %0d", cyc);
    end
    bus.dividend = a;
    bus.divisor = b;
    bus.start = 1'b1;
    predict(a, b);
    @(negedge clock);
    bus.start = 1'b0;
    bus.dividend = $urandom;
    bus.divisor = $urandom;
    chk("busy_after_start", {31'b0, bus.busy}, {31'b0, b != 0});
  endtask

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clock)
    if (reset && bus.done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done got done=1 expected no pending op at cycle %0d", cyc);
      end else begin
        me = q.pop_front();
        chk("lo", bus.lo, me.lo);
        chk("hi", bus.hi, me.hi);
        chk("div_zero", {31'b0, bus.div_zero}, {31'b0, me.dz});
        chk("latency", cyc - me.cyc, me.lat);
        chk("busy_at_done", {31'b0, bus.busy}, 32'd0);
      end
    end

  initial begin
    int issue, n;
    logic [31:0] a, b;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(negedge clock);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_busy", {31'b0, bus.busy}, 0);
    chk("rst_done", {31'b0, bus.done}, 0);
    chk("rst_div_zero", {31'b0, bus.div_zero}, 0);
    reset = 1'b1;
    @(negedge clock);
    do_div(7, 2);
    do_div(32'hFFFF_FFF9, 2);
    do_div(7, 32'hFFFF_FFFE);
    do_div(32'hFFFF_FFF9, 32'hFFFF_FFFE);
    do_div(7, 2);
    do_div(5, 0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF);
    do_div(32'h8000_0000, 1);
    do_div(0, 9);
    do_div(3, 0);
    do_div(0, 0);
    // start while busy must be ignored
    do_div(100, 7);
    issue = cyc - 1;
    while (cyc < issue + 9) @(negedge clock);
    bus.dividend = 9;
    bus.divisor = 3;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    // asynchronous reset mid-operation clears outputs without a clock edge
    do_div(100, 7);
    issue = cyc - 1;
    while (cyc < issue + 19) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", {31'b0, bus.busy}, 0);
    chk("arst_done", {31'b0, bus.done}, 0);
    chk("arst_hi", bus.hi, 0);
    chk("arst_lo", bus.lo, 0);
    q.delete();
    last_lo = '0;
    last_hi = '0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    do_div(100, 7);
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: b = $urandom_range(0, 1) ? $urandom_range(1, 15) : -$urandom_range(1, 15);
        2: begin a = 32'h8000_0000; b = $urandom; end
        default: b = $urandom;
      endcase
      do_div(a, b);
    end
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential signed 32-bit divider for the multicycle CPU, implementing MIPS DIV semantics.
- Sits downstream of the A/B operand registers and upstream of the HI/LO muxes.
- Consumes RegAOut as the dividend and RegBOut as the divisor.
- Produces the remainder (HI) and quotient (LO) plus a divide-by-zero flag, which the control unit uses to raise the exception.
- Uses restoring shift-subtract on magnitudes with sign fix-up.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request from control; sampled only in IDLE
dividend  input  WIDTH  signed dividend (RegAOut)
divisor  input  WIDTH  signed divisor (RegBOut)
hi  output  WIDTH  remainder, registered
lo  output  WIDTH  quotient, registered
busy  output  1  high in CALC and FIX
done  output  1  one-cycle completion pulse
div_zero  output  1  divisor was zero on last accepted start; registered

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - hi=0, lo=0, busy=0, done=0, div_zero=0.
  - Internal count, remainder and quotient registers cleared.
  - Reset mid-operation aborts immediately; no done pulse follows.
- States: IDLE, CALC, FIX.
- IDLE:
  - done=0 except for the single cycle following completion.
  - On an edge with start=1 and divisor==0:
    - Stay in IDLE and set div_zero=1.
    - done=1 for the next cycle only.
    - hi/lo unchanged.
    - Latency 1 edge.
  - On an edge with start=1 and divisor!=0:
    - Latch |dividend| into the quotient shift register and |divisor| into the magnitude register.
    - Clear the partial remainder (WIDTH+1 bits); latch both operand sign bits.
    - Set div_zero=0, count=0, busy=1; go to CALC.
- CALC, one iteration per edge:
  - Shift {rem, quo} left by 1.
  - Trial subtract: rem - |divisor|. If non-negative, keep the difference and set quo[0]=1; else restore and set quo[0]=0.
  - count increments; after the iteration with count==WIDTH-1, go to FIX.
- FIX, one edge:
  - lo = quo, negated if the operand signs differ.
  - hi = rem, negated if the dividend is negative.
  - done=1 for the following cycle; busy=0; go to IDLE.
- Latency: start edge plus WIDTH CALC edges plus 1 FIX edge = 34 edges. done is observed high after edge 34, with hi/lo valid in the same cycle.
- Results are held until the next completion. div_zero is held until the next accepted start.
- Semantics: quotient truncates toward zero; the remainder takes the sign of the dividend.
- Magnitudes: |x| is computed in WIDTH bits, so |0x80000000| = 0x80000000, treated as unsigned.
- Overflow case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; no flag.
- start while busy=1: ignored. Inputs may change freely after the start edge.
- start asserted in the same cycle as the done pulse: accepted; the new operation begins and done deasserts next cycle.
- Control must not write HI/LO from this block unless done=1 and div_zero=0.

Test Plan:
1. dividend=7, divisor=2, pulse start -> done after 34 edges; lo=0x00000003, hi=0x00000001, div_zero=0; busy high for edges 1..33 after the start edge.
2. dividend=-7 (0xFFFFFFF9), divisor=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then 7 / -2 -> lo=0xFFFFFFFD, hi=0x00000001. Then -7 / -2 -> lo=0x00000003, hi=0xFFFFFFFF.
3. Prior result lo=3, hi=1; then dividend=5, divisor=0 -> done one edge after start, div_zero=1, lo=3 and hi=1 unchanged, busy never high.
4. dividend=0x80000000, divisor=0xFFFFFFFF -> lo=0x80000000, hi=0. Then 0x80000000 / 1 -> lo=0x80000000, hi=0.
5. Start 100/7; re-pulse start with 9/3 at edge 10 -> second start ignored; result lo=14, hi=2 at edge 34; exactly one done pulse.
6. Start 100/7; drive reset=0 asynchronously mid-cycle at edge 20 -> busy, done, hi and lo go 0 immediately with no clock. Release reset, start 100/7 again -> lo=14, hi=2 after 34 edges.
